// File: rtl/vect_pkg.sv
// vect_pkg: vector-unit bus types and constants shared by the VLSU and its memory slave
package vect_pkg;
  localparam logic [31:0] AHB_IDLE_ADDR = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {AHB_OKAY = 2'b00, AHB_ERROR = 2'b01} ahb_resp_e;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2} ahb_slv_fsm_t;
endpackage

// File: rtl/sp_sram.sv
// sp_sram: single-port synchronous RAM with one-cycle read latency
module sp_sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/ahb_vmem_responder.sv
// ahb_vmem_responder: word-addressed AHB-style data-memory slave with wait states and ERROR responses
module ahb_vmem_responder
  import vect_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic [1:0]            hresp_o
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  ahb_slv_fsm_t state, state_nx;
  logic [IW-1:0] idx_q, idx_nx, dec_idx, sram_addr;
  logic write_q, write_nx, dec_err, req, sram_en, sram_we, unused_hsize;
  logic [3:0] cnt_q, cnt_nx;
  logic [ADDR_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] sram_rdata;
  assign off          = haddr_i - BASE_ADDR;
  assign dec_idx      = off[IW+1:2];
  assign dec_err      = haddr_i < BASE_ADDR || (off >> 2) >= ADDR_WIDTH'(MEM_DEPTH) || haddr_i[1:0] != 2'b00;
  assign req          = haddr_i != ADDR_WIDTH'(AHB_IDLE_ADDR);
  assign unused_hsize = ^hsize_i;
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      idx_q   <= idx_nx;
      write_q <= write_nx;
      cnt_q   <= cnt_nx;
    end
  always_comb begin
    state_nx  = state;
    idx_nx    = idx_q;
    write_nx  = write_q;
    cnt_nx    = cnt_q;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = idx_q;
    hready_o  = 1'b0;
    hresp_o   = AHB_OKAY;
    case (state)
      S_IDLE:
        if (req) begin
          idx_nx   = dec_idx;
          write_nx = hwrite_i;
          if (dec_err) state_nx = S_ERR1;
          else if (WAIT_STATES == 0) begin
            state_nx  = S_RESP;
            sram_en   = !hwrite_i;
            sram_addr = dec_idx;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_STATES - 1);
          end
        end
      S_WAIT:
        if (cnt_q == 4'd0) begin
          state_nx = S_RESP;
          sram_en  = !write_q;
        end else cnt_nx = cnt_q - 4'd1;
      S_RESP: begin
        hready_o = 1'b1;
        sram_en  = write_q;
        sram_we  = write_q;
        state_nx = S_IDLE;
      end
      S_ERR1: begin
        hresp_o  = AHB_ERROR;
        state_nx = S_ERR2;
      end
      S_ERR2: begin
        hready_o = 1'b1;
        hresp_o  = AHB_ERROR;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // read data is only driven in a read completion cycle, otherwise the bus reads 0
  assign hrdata_o = (state == S_RESP && !write_q) ? sram_rdata : '0;
  sp_sram #(.WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_sram (
    .clk_i  (clk_i),
    .en_i   (sram_en),
    .we_i   (sram_we),
    .addr_i (sram_addr),
    .wdata_i(hwdata_i),
    .rdata_o(sram_rdata)
  );
endmodule

// File: tb/tb_ahb_vmem_responder.sv
// tb_ahb_vmem_responder: directed plus randomized checks of three responders with 0, 1 and 3 wait states
module tb_ahb_vmem_responder;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
  localparam int WS [3] = '{0, 1, 3};
  logic clk = 1'b0;
  logic rstn [3];
  logic [31:0] haddr [3];
  logic hwrite [3];
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];
  logic hready [3];
  logic [1:0] hresp [3];
  int checks = 0;
  int failures = 0;
  logic [31:0] model [int];
  always #5 clk = ~clk;

  ahb_vmem_responder #(.WAIT_STATES(0)) u0 (.clk_i(clk), .resetn_i(rstn[0]), .haddr_i(haddr[0]), .hwrite_i(hwrite[0]),
    .hsize_i(3'b011), .hwdata_i(hwdata[0]), .hrdata_o(hrdata[0]), .hready_o(hready[0]), .hresp_o(hresp[0]));
  ahb_vmem_responder #(.WAIT_STATES(1)) u1 (.clk_i(clk), .resetn_i(rstn[1]), .haddr_i(haddr[1]), .hwrite_i(hwrite[1]),
    .hsize_i(3'b011), .hwdata_i(hwdata[1]), .hrdata_o(hrdata[1]), .hready_o(hready[1]), .hresp_o(hresp[1]));
  ahb_vmem_responder #(.WAIT_STATES(3)) u3 (.clk_i(clk), .resetn_i(rstn[2]), .haddr_i(haddr[2]), .hwrite_i(hwrite[2]),
    .hsize_i(3'b011), .hwdata_i(hwdata[2]), .hrdata_o(hrdata[2]), .hready_o(hready[2]), .hresp_o(hresp[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int key(input int k, input logic [31:0] a);
    return k * 4096 + int'(a >> 2);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return a % 4 != 0 || a / 4 >= 1024;
  endfunction

  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [31:0] d, input string tag);
    int lat;
    logic mid_bad, err;
    logic [1:0] exp_resp;
    logic [31:0] exp_d;
    err      = bad_addr(a);
    exp_resp = err ? 2'b01 : 2'b00;
    exp_d    = (!err && !w) ? model[key(k, a)] : 32'h0;
    @(negedge clk);
    haddr[k] = a; hwrite[k] = w; hwdata[k] = d;
    chk({tag, "_addr_cycle_rdy"}, 32'(hready[k]), 32'h0);
    lat = 0; mid_bad = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (hready[k]) break;
      if (hresp[k] !== exp_resp) mid_bad = 1'b1;
    end
    chk({tag, "_latency"}, 32'(lat), err ? 32'd2 : 32'(1 + WS[k]));
    chk({tag, "_wait_resp"}, 32'(mid_bad), 32'h0);
    chk({tag, "_resp"}, 32'(hresp[k]), 32'(exp_resp));
    chk({tag, "_rdata"}, hrdata[k], exp_d);
    haddr[k] = IDLE; hwrite[k] = 1'b0;
    if (!err && w) model[key(k, a)] = d;
    @(posedge clk);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    logic w;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; haddr[k] = IDLE; hwrite[k] = 1'b0; hwdata[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdy", 32'(hready[k]), 32'h0);
      chk("reset_resp", 32'(hresp[k]), 32'h0);
      chk("reset_rdata", hrdata[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    @(posedge clk);

    xfer(1, 32'h100, 1'b1, 32'hDEAD_BEEF, "ws1_wr");
    xfer(1, 32'h100, 1'b0, 32'h0, "ws1_rd");

    for (int i = 0; i < 4; i++) xfer(0, 32'(4 * i), 1'b1, 32'(17 * (i + 1)), "ws0_pre");
    for (int i = 0; i < 4; i++) xfer(0, 32'(4 * i), 1'b0, 32'h0, "ws0_rd");

    xfer(1, 32'hFFC, 1'b1, 32'hA5A5_0001, "top_wr");
    xfer(1, 32'h1000, 1'b0, 32'h0, "oor_rd");
    xfer(1, 32'h1000, 1'b1, 32'h5555_AAAA, "oor_wr");
    xfer(1, 32'hFFC, 1'b0, 32'h0, "top_rd");
    xfer(1, 32'h102, 1'b1, 32'h1234_5678, "mis_wr");
    xfer(1, 32'h100, 1'b0, 32'h0, "mis_chk");
    @(negedge clk);
    haddr[1] = IDLE;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_hold_rdy", 32'(hready[1]), 32'h0);
    end

    xfer(2, 32'h20, 1'b1, 32'hCAFE_0000, "ws3_wr");
    @(negedge clk);
    haddr[2] = 32'h20; hwrite[2] = 1'b1; hwdata[2] = 32'h0BAD_0BAD;
    @(posedge clk);
    @(posedge clk); #2;
    rstn[2] = 1'b0;
    #1;
    chk("midrst_rdy", 32'(hready[2]), 32'h0);
    chk("midrst_resp", 32'(hresp[2]), 32'h0);
    chk("midrst_rdata", hrdata[2], 32'h0);
    haddr[2] = IDLE; hwrite[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b1;
    @(posedge clk);
    xfer(2, 32'h20, 1'b0, 32'h0, "midrst_rd");

    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 25; n++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7) a = 32'h200 + 32'(4 * $urandom_range(0, 7));
        else if (sel == 7) a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
        else if (sel == 8) a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
        else a = 32'hFFC;
        w = 1'($urandom_range(0, 1));
        if (!w && !bad_addr(a) && !model.exists(key(k, a))) w = 1'b1;
        xfer(k, a, w, $urandom, "rand");
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
